// File: rtl/array_init_ctrl.sv
// Front-end controller that sweeps a DEPTH x WIDTH array with an init value after reset/flush,
// then forwards client reads/writes. Optional macro ARRAY_INIT_PATTERN_EN selects an address-tagged init pattern.
module array_init_ctrl #(
   parameter int DEPTH  = 32,
   parameter int WIDTH  = 112,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_req,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [WIDTH-1:0]  mem_wdata,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic              init_done,
   output logic              busy
);

   typedef enum logic {
      S_INIT,
      S_READY
   } state_e;

   state_e              state_q;
   logic [ADDR_W-1:0]   ptr_q;
   logic                mem_wen_q;
   logic [ADDR_W-1:0]   mem_waddr_q;
   logic [WIDTH-1:0]    mem_wdata_q;
   logic                mem_ren_q;
   logic [ADDR_W-1:0]   mem_raddr_q;

   logic                wr_acc;
   logic                rd_acc;
   logic [WIDTH-1:0]    init_word;

   always_comb begin
`ifdef ARRAY_INIT_PATTERN_EN
      init_word = {(WIDTH/8){3'b101, ptr_q}};
`else
      init_word = (ptr_q == ptr_q) ? '0 : '1;
`endif
   end

   // A read colliding with a same-cycle write to the same entry is held off so the write lands first.
   always_comb begin
      wr_ready = (state_q == S_READY);
      rd_ready = (state_q == S_READY) && !(wr_valid && rd_valid && (wr_addr == rd_addr));
      wr_acc   = wr_valid && wr_ready;
      rd_acc   = rd_valid && rd_ready;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_INIT;
         ptr_q       <= '0;
         mem_wen_q   <= 1'b0;
         mem_waddr_q <= '0;
         mem_wdata_q <= '0;
         mem_ren_q   <= 1'b0;
         mem_raddr_q <= '0;
      end else begin
         case (state_q)
            S_INIT: begin
               mem_wen_q   <= 1'b1;
               mem_waddr_q <= ptr_q;
               mem_wdata_q <= init_word;
               mem_ren_q   <= 1'b0;
               if (flush_req) begin
                  ptr_q <= '0;
               end else if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                  ptr_q   <= '0;
                  state_q <= S_READY;
               end else begin
                  ptr_q <= ptr_q + ADDR_W'(1);
               end
            end
            default: begin
               mem_wen_q <= wr_acc;
               if (wr_acc) begin
                  mem_waddr_q <= wr_addr;
                  mem_wdata_q <= wr_data;
               end
               mem_ren_q <= rd_acc;
               if (rd_acc) begin
                  mem_raddr_q <= rd_addr;
               end
               if (flush_req) begin
                  state_q <= S_INIT;
                  ptr_q   <= '0;
               end
            end
         endcase
      end
   end

   assign mem_wen   = mem_wen_q;
   assign mem_waddr = mem_waddr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_ren   = mem_ren_q;
   assign mem_raddr = mem_raddr_q;
   assign init_done = (state_q == S_READY);
   assign busy      = (state_q == S_INIT);

endmodule
